// File: rtl/mem_port_sched.sv
// rtl/mem_port_sched.sv - byte-beat RAM sequencer shared by load/store and fetch
// Optional round-robin arbitration when MEMARB_RR_EN is defined.
module mem_port_sched #(
    parameter int RAM_AW   = 20,
    parameter bit LS_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_done,
    output logic        ls_err,
    output logic [31:0] ls_rdata,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic        if_err,
    output logic [31:0] if_rdata,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, XFER, LAST, RESP} state_t;

    state_t      state_q;
    logic        owner_ls_q, we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, lanes_q;
    logic [1:0]  cnt_q, lastk_q;
    logic        ls_done_q, ls_err_q, if_done_q, if_err_q;
    logic [31:0] ls_rdata_q, if_rdata_q;

    logic        ls_win, req_we, req_bad;
    logic [2:0]  req_f3;
    logic [31:0] req_addr, final_word;
    logic [1:0]  req_lastk;
    logic [32:0] req_end;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'd0:    extend = {{24{w[7]}}, w[7:0]};
            3'd4:    extend = {24'd0, w[7:0]};
            3'd1:    extend = {{16{w[15]}}, w[15:0]};
            3'd5:    extend = {16'd0, w[15:0]};
            default: extend = w;
        endcase
    endfunction

`ifdef MEMARB_RR_EN
    logic last_ls_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_ls_q <= 1'b0;
        end else if (ls_gnt || if_gnt) begin
            last_ls_q <= ls_gnt;
        end
    end
`endif

    always_comb begin
`ifdef MEMARB_RR_EN
        ls_win = ls_req && (!if_req || !last_ls_q);
`else
        ls_win = ls_req && (!if_req || LS_FIRST);
`endif
        ls_gnt   = (state_q == IDLE) && ls_win;
        if_gnt   = (state_q == IDLE) && if_req && !ls_win;
        req_we   = ls_win ? ls_we : 1'b0;
        req_f3   = ls_win ? ls_funct3 : 3'd2;
        req_addr = ls_win ? ls_addr : if_addr;
        case (req_f3[1:0])
            2'd0:    req_lastk = 2'd0;
            2'd1:    req_lastk = 2'd1;
            default: req_lastk = 2'd3;
        endcase
        // 33-bit end address so a wrap past 0xFFFFFFFF falls outside the window
        req_end = {1'b0, req_addr} + {31'd0, req_lastk};
        req_bad = (req_f3[1:0] == 2'd3)
               || (req_f3[2] && (req_f3[1] || req_we))
               || ((req_f3[1:0] == 2'd1) && req_addr[0])
               || ((req_f3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0))
               || ((req_addr >> RAM_AW) != 32'd1)
               || ((req_end >> RAM_AW) != 33'd1);
        final_word = lanes_q;
        final_word[{lastk_q, 3'b000} +: 8] = ram_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_ls_q <= 1'b0;
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            lanes_q    <= 32'd0;
            cnt_q      <= 2'd0;
            lastk_q    <= 2'd0;
            ls_done_q  <= 1'b0;
            ls_err_q   <= 1'b0;
            if_done_q  <= 1'b0;
            if_err_q   <= 1'b0;
            ls_rdata_q <= 32'd0;
            if_rdata_q <= 32'd0;
        end else begin
            ls_done_q <= 1'b0;
            ls_err_q  <= 1'b0;
            if_done_q <= 1'b0;
            if_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ls_gnt || if_gnt) begin
                        owner_ls_q <= ls_gnt;
                        we_q       <= req_we;
                        f3_q       <= req_f3;
                        addr_q     <= req_addr;
                        wdata_q    <= ls_wdata;
                        lastk_q    <= req_lastk;
                        cnt_q      <= 2'd0;
                        if (req_bad) begin
                            state_q   <= RESP;
                            ls_done_q <= ls_gnt;
                            ls_err_q  <= ls_gnt;
                            if_done_q <= if_gnt;
                            if_err_q  <= if_gnt;
                        end else begin
                            state_q <= XFER;
                        end
                    end
                end
                XFER: begin
                    // read data lags the address by one cycle, so lane k lands during beat k+1
                    if (!we_q && (cnt_q != 2'd0)) begin
                        lanes_q[{cnt_q - 2'd1, 3'b000} +: 8] <= ram_rdata;
                    end
                    if (cnt_q == lastk_q) begin
                        if (we_q) begin
                            state_q   <= RESP;
                            ls_done_q <= owner_ls_q;
                            if_done_q <= !owner_ls_q;
                        end else begin
                            state_q <= LAST;
                        end
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                LAST: begin
                    state_q <= RESP;
                    if (owner_ls_q) begin
                        ls_rdata_q <= extend(f3_q, final_word);
                        ls_done_q  <= 1'b1;
                    end else begin
                        if_rdata_q <= final_word;
                        if_done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_we    = (state_q == XFER) && we_q;
    assign ram_addr  = (state_q == XFER) ? addr_q + {30'd0, cnt_q} : 32'd0;
    assign ram_wdata = ram_we ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'd0;
    assign busy      = (state_q != IDLE);
    assign ls_done   = ls_done_q;
    assign ls_err    = ls_err_q;
    assign ls_rdata  = ls_rdata_q;
    assign if_done   = if_done_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
endmodule

// File: tb/tb_mem_port_sched.sv
// tb/tb_mem_port_sched.sv - scoreboard bench for mem_port_sched with a byte RAM model
module tb_mem_port_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ls_req = 1'b0, ls_we = 1'b0;
    logic [2:0]  ls_funct3 = 3'd0;
    logic [31:0] ls_addr = 32'd0, ls_wdata = 32'd0;
    logic        ls_gnt, ls_done, ls_err;
    logic [31:0] ls_rdata;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_gnt, if_done, if_err;
    logic [31:0] if_rdata;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'd0;
    logic        busy;

    mem_port_sched dut (
        .clk(clk), .reset(reset),
        .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_err(ls_err),
        .ls_rdata(ls_rdata), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          ls_gnt_cyc = 0;
    int          if_gnt_cyc = 0;
    logic [31:0] exp_ls_rdata = 32'd0;
    logic [31:0] exp_if_rdata = 32'd0;
    exp_t        ls_q[$];
    exp_t        if_q[$];
    wr_t         wlog[$];
    logic        gnt_log[$];
    logic [7:0]  mem [logic [31:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) begin
            mem[ram_addr] = ram_wdata;
            wlog.push_back('{cyc, ram_addr, ram_wdata});
        end
        ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : 8'h00;
    end

    always @(negedge clk) begin
        exp_t e;
        if (ls_gnt) gnt_log.push_back(1'b1);
        if (if_gnt) gnt_log.push_back(1'b0);
        if (ls_done) begin
            if (ls_q.size() == 0) begin
                chk("ls_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = ls_q.pop_front();
                chk("ls_done_cycle", cyc, e.cyc);
                chk("ls_err", ls_err, e.err);
                chk("ls_rdata", ls_rdata, e.rdata);
            end
        end
        if (if_done) begin
            if (if_q.size() == 0) begin
                chk("if_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = if_q.pop_front();
                chk("if_done_cycle", cyc, e.cyc);
                chk("if_err", if_err, e.err);
                chk("if_rdata", if_rdata, e.rdata);
            end
        end
    end

    task automatic ls_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic err, input logic [31:0] rdata);
        int g;
        int lat;
        logic got;
        got = 1'b0;
        g = 0;
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wdata;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (ls_gnt) begin
                got = 1'b1;
                g = cyc;
            end
        end
        if (!got) begin
            chk("ls_gnt_timeout", 32'd0, 32'd1);
        end else begin
            lat = err ? 1 : (we ? (f3[1:0] == 2'd0 ? 2 : f3[1:0] == 2'd1 ? 3 : 5)
                                : (f3[1:0] == 2'd0 ? 3 : f3[1:0] == 2'd1 ? 4 : 6));
            if (!err && !we) exp_ls_rdata = rdata;
            ls_q.push_back('{g + lat, err, exp_ls_rdata});
            ls_gnt_cyc = g;
        end
        @(posedge clk); #1;
        ls_req = 1'b0;
    endtask

    task automatic if_op(input logic [31:0] addr, input logic err, input logic [31:0] rdata);
        int g;
        logic got;
        got = 1'b0;
        g = 0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = addr;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (if_gnt) begin
                got = 1'b1;
                g = cyc;
            end
        end
        if (!got) begin
            chk("if_gnt_timeout", 32'd0, 32'd1);
        end else begin
            if (!err) exp_if_rdata = rdata;
            if_q.push_back('{g + (err ? 1 : 6), err, exp_if_rdata});
            if_gnt_cyc = g;
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 100 && (ls_q.size() != 0 || if_q.size() != 0 || busy)) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < 100, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic exp_order [4];
`ifdef MEMARB_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 32'd0);
        chk("rst_ram_we", ram_we, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_outs", {ls_gnt, ls_done, ls_err, if_gnt, if_done, if_err}, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        reset = 1'b1;

        wlog.delete();
        ls_op(1'b1, 3'd2, 32'h0010_0000, 32'hA1B2_C3D4, 1'b0, 32'd0);
        wait_idle();
        chk("sw_beats", wlog.size(), 32'd4);
        if (wlog.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("sw_beat_cycle", wlog[k].cyc, ls_gnt_cyc + 1 + k);
                chk("sw_beat_addr", wlog[k].addr, 32'h0010_0000 + k);
            end
            chk("sw_byte0", wlog[0].data, 32'hD4);
            chk("sw_byte1", wlog[1].data, 32'hC3);
            chk("sw_byte2", wlog[2].data, 32'hB2);
            chk("sw_byte3", wlog[3].data, 32'hA1);
        end

        ls_op(1'b0, 3'd2, 32'h0010_0000, 32'd0, 1'b0, 32'hA1B2_C3D4);
        ls_op(1'b0, 3'd0, 32'h0010_0003, 32'd0, 1'b0, 32'hFFFF_FFA1);
        ls_op(1'b0, 3'd4, 32'h0010_0003, 32'd0, 1'b0, 32'h0000_00A1);
        ls_op(1'b0, 3'd1, 32'h0010_0002, 32'd0, 1'b0, 32'hFFFF_A1B2);
        ls_op(1'b0, 3'd5, 32'h0010_0002, 32'd0, 1'b0, 32'h0000_A1B2);
        wait_idle();

        wlog.delete();
        ls_op(1'b0, 3'd2, 32'h0010_0001, 32'd0, 1'b1, 32'd0);
        ls_op(1'b1, 3'd1, 32'h0010_0003, 32'h5555_5555, 1'b1, 32'd0);
        ls_op(1'b0, 3'd3, 32'h0010_0000, 32'd0, 1'b1, 32'd0);
        ls_op(1'b0, 3'd2, 32'h001F_FFFE, 32'd0, 1'b1, 32'd0);
        ls_op(1'b0, 3'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0);
        if_op(32'h0000_0000, 1'b1, 32'd0);
        wait_idle();
        chk("err_no_writes", wlog.size(), 32'd0);

        gnt_log.delete();
        fork
            ls_op(1'b0, 3'd2, 32'h0010_0000, 32'd0, 1'b0, 32'hA1B2_C3D4);
            if_op(32'h0010_0000, 1'b0, 32'hA1B2_C3D4);
        join
        wait_idle();
        chk("simul_first_ls", (gnt_log.size() > 0) ? gnt_log[0] : 1'b0, 32'd1);
        chk("simul_if_after_done", if_gnt_cyc, ls_gnt_cyc + 7);

        gnt_log.delete();
        fork
            begin
                ls_op(1'b0, 3'd2, 32'h0010_0000, 32'd0, 1'b0, 32'hA1B2_C3D4);
                ls_op(1'b0, 3'd1, 32'h0010_0000, 32'd0, 1'b0, 32'hFFFF_C3D4);
            end
            begin
                if_op(32'h0010_0000, 1'b0, 32'hA1B2_C3D4);
                if_op(32'h0010_0000, 1'b0, 32'hA1B2_C3D4);
            end
        join
        wait_idle();
        chk("order_len", gnt_log.size(), 32'd4);
        if (gnt_log.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("grant_order", gnt_log[k], exp_order[k]);
        end

        ls_op(1'b1, 3'd2, 32'h0010_0010, 32'hDEAD_BEEF, 1'b0, 32'd0);
        wait_idle();
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = 3'd2;
        ls_addr = 32'h0010_0010; ls_wdata = 32'h1122_3344;
        @(negedge clk);
        chk("rst_sw_gnt", ls_gnt, 32'd1);
        @(posedge clk); #1;
        ls_req = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        chk("beat2_we", ram_we, 32'd1);
        chk("beat2_addr", ram_addr, 32'h0010_0012);
        reset = 1'b0;
        #1;
        chk("arst_ram_we", ram_we, 32'd0);
        chk("arst_ram_addr", ram_addr, 32'd0);
        chk("arst_busy", busy, 32'd0);
        chk("arst_ls_rdata", ls_rdata, 32'd0);
        chk("arst_if_rdata", if_rdata, 32'd0);
        chk("arst_flags", {ls_done, ls_err, if_done, if_err, ram_wdata}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_ls_rdata = 32'd0;
        exp_if_rdata = 32'd0;
        ls_op(1'b0, 3'd2, 32'h0010_0010, 32'd0, 1'b0, 32'hDEAD_3344);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_sched.md
Name: mem_port_sched

Overview:
- Sequencer/arbiter sharing the single byte-wide data RAM between two requesters: load/store unit (ls_*) and instruction fetch (if_*).
- Each granted access is split into 1, 2 or 4 little-endian byte beats on the RAM port.
- Load results are assembled with LB/LH/LW/LBU/LHU sign/zero extension.
- Misaligned, illegal or out-of-window requests are rejected without touching RAM.

Parameters:
- RAM_AW, 20: RAM window is byte addresses [2**RAM_AW, 2*2**RAM_AW); every beat of an access must fall inside it.
- LS_FIRST, 1: fixed-priority winner on a simultaneous request (1 = load/store, 0 = fetch). Ignored when MEMARB_RR_EN is defined.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ls_req  in  1  load/store request; held until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_funct3  in  3  access code: 0 B, 1 H, 2 W, 4 BU, 5 HU (loads); 0/1/2 only for stores
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data; low bytes are used for B/H
- ls_gnt  out  1  one-cycle accept pulse
- ls_done  out  1  one-cycle completion pulse
- ls_err  out  1  valid with ls_done: request rejected
- ls_rdata  out  32  extended load result
- if_req  in  1  fetch request (always an unsigned word load)
- if_addr  in  32  fetch byte address
- if_gnt  out  1  accept pulse
- if_done  out  1  completion pulse
- if_err  out  1  valid with if_done
- if_rdata  out  32  fetched word
- ram_addr  out  32  beat address
- ram_we  out  1  byte write strobe
- ram_wdata  out  8  byte written
- ram_rdata  in  8  synchronous read data, valid the cycle after ram_addr
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, reset=0):
  - FSM goes to IDLE.
  - All outputs are 0; rdata registers are 0.
  - ram_we drops immediately.
  - A partially written store is not rolled back.
- States:
  - IDLE: arbitrate.
  - XFER: issue beats 0..n-1, one per cycle.
  - LAST: loads only; capture the final byte.
  - RESP: pulse done.
- IDLE:
  - With any req, gnt is asserted combinationally to the winner that cycle.
  - op, addr, funct3, wdata and we are latched at the clock edge.
  - Request inputs are ignored outside the gnt cycle.
  - Dropping req before gnt has no effect.
- Validity check at gnt. The request is an error if any of these holds:
  - funct3 is illegal.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - First or last byte is outside the RAM window.
  - Error path: the next state is RESP, with no RAM beats and err=1.
- n = 1/2/4 for B/H/W.
- XFER cycle k (k=0..n-1):
  - ram_addr = addr+k.
  - Stores: ram_we=1 and ram_wdata = wdata[8k+7:8k].
  - Loads: ram_we=0; the byte issued in cycle k is captured into lane k at the end of cycle k+1.
- After XFER: loads go to LAST, stores go to RESP.
- Outputs when not in XFER: ram_we=0 and ram_addr=0.
- Latency, with the gnt cycle as cycle 0:
  - Load done at cycle n+2.
  - Store done at cycle n+1.
  - Error done at cycle 1.
  - Example: LW done at cycle 6; SW done at cycle 5.
- RESP:
  - The owner's done pulses for 1 cycle, with err.
  - The owner's rdata updates on entry to RESP and holds until that owner's next done.
  - Stores and errors leave rdata unchanged.
  - The FSM returns to IDLE and can grant again in that same IDLE cycle, so back-to-back accesses have exactly 1 IDLE cycle between them.
- Extension:
  - LB sign-extends byte 0; LBU zero-extends it.
  - LH sign-extends bytes 1:0; LHU zero-extends them.
  - LW passes all 4 bytes.
- The non-owner's gnt and done stay 0 throughout an access; its pending req waits in IDLE.
- Address arithmetic is 32-bit. The window check uses addr+n-1 and also rejects 32-bit wrap-around (e.g. 0xFFFFFFFF).

Optional Feature:
- MEMARB_RR_EN defined:
  - Round-robin arbitration; a 1-bit last-owner flag is reset to "fetch".
  - On simultaneous requests, the requester not granted last wins.
  - The flag updates on every gnt.
- Undefined: fixed priority per LS_FIRST; the flag logic is absent.

Test Plan:
- SW: addr 0x100000, data 0xA1B2C3D4 -> cycles 1-4 write bytes D4,C3,B2,A1 to 0x100000-0x100003; ls_done at cycle 5 with err=0. Then LW from the same address -> ls_rdata=0xA1B2C3D4 at cycle 6.
- LB at 0x100003 holding 0xA1 -> 0xFFFFFFA1. LBU -> 0x000000A1. LH at 0x100002 -> 0xFFFFA1B2. LHU -> 0x0000A1B2.
- Error cases, each done at cycle 1 with err=1, no ram_we and rdata unchanged:
  - LW at 0x100001.
  - SH at 0x100003.
  - ls_funct3=3.
  - LW at 0x1FFFFE (last byte outside the window).
  - fetch at 0x0.
- ls_req and if_req both high in the same cycle, with LS_FIRST=1 and no MEMARB_RR_EN -> ls granted; fetch granted in the IDLE cycle after ls_done.
- Same stimulus with MEMARB_RR_EN, held for 4 accesses -> grants alternate ls, if, ls, if.
- reset pulled low during beat 2 of an SW -> ram_we=0 immediately and all outputs 0. After release, IDLE accepts a new LW and returns bytes 0,1 new and bytes 2,3 old.
